mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 83 ++++++++
 tb/tb_mul_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit: 32x32 iterative shift-add multiplier (MUL/MLA/UMULL/SMULL), 34-cycle latency, with N/Z flags.
module mul_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        s,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] acc,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        long_op,
  output logic [3:0]  cond_flags,
  output logic [1:0]  flag_w
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t      state;
  logic [4:0]  count;
  logic [63:0] prod;
  logic [31:0] mcand, acc_q;
  logic [1:0]  op_q;
  logic        s_q, neg;
  logic        smull, accept, n_f, z_f;
  logic [31:0] abs_a, abs_b, lo, hi;
  logic [32:0] sum;
  logic [63:0] fixed;
  always_comb begin
    smull  = op == 2'b11;
    accept = start && (state == IDLE || state == DONE);
    abs_a  = smull && a[31] ? -a : a;
    abs_b  = smull && b[31] ? -b : b;
    sum    = {1'b0, prod[63:32]} + {1'b0, prod[0] ? mcand : 32'd0};
    fixed  = neg ? -prod : prod;
    lo     = fixed[31:0] + (op_q == 2'b01 ? acc_q : 32'd0);
    hi     = op_q[1] ? fixed[63:32] : 32'd0;
    n_f    = op_q[1] ? hi[31] : lo[31];
    z_f    = {hi, lo} == 64'd0;
  end
  assign busy = state == CALC || state == FIX;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 5'd0;
      prod       <= 64'd0;
      mcand      <= 32'd0;
      acc_q      <= 32'd0;
      op_q       <= 2'b00;
      s_q        <= 1'b0;
      neg        <= 1'b0;
      result_lo  <= 32'd0;
      result_hi  <= 32'd0;
      long_op    <= 1'b0;
      cond_flags <= 4'd0;
      flag_w     <= 2'b00;
    end else if (accept) begin
      state <= CALC;
      count <= 5'd0;
      prod  <= {32'd0, abs_b};
      mcand <= abs_a;
      acc_q <= acc;
      op_q  <= op;
      s_q   <= s;
      neg   <= smull && (a[31] ^ b[31]);
    end else if (state == CALC) begin
      prod  <= {sum, prod[31:1]};
      count <= count + 5'd1;
      state <= count == 5'd31 ? FIX : CALC;
    end else if (state == FIX) begin
      result_lo  <= lo;
      result_hi  <= hi;
      long_op    <= op_q[1];
      cond_flags <= {n_f, z_f, 2'b00};
      flag_w     <= s_q ? 2'b01 : 2'b00;
      state      <= DONE;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: randomized and directed checks of mul_unit against an arithmetic reference model.
module tb_mul_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, s = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0, acc = 32'd0;
  logic        busy, done, long_op;
  logic [31:0] result_lo, result_hi;
  logic [3:0]  cond_flags;
  logic [1:0]  flag_w;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] lo, hi;
    logic        lng;
    logic [3:0]  fl;
    logic [1:0]  fw;
  } exp_t;

  mul_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .s(s), .a(a), .b(b), .acc(acc),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .long_op(long_op), .cond_flags(cond_flags), .flag_w(flag_w)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [1:0] o, logic sv, logic [31:0] av, bv, cv);
    exp_t e;
    logic [63:0] p;
    logic signed [63:0] sa, sb;
    sa = $signed(av);
    sb = $signed(bv);
    case (o)
      2'b00:   p = {32'd0, av * bv};
      2'b01:   p = {32'd0, av * bv + cv};
      2'b10:   p = {32'd0, av} * {32'd0, bv};
      default: p = sa * sb;
    endcase
    e.lo  = p[31:0];
    e.hi  = p[63:32];
    e.lng = o[1];
    e.fl  = {o[1] ? p[63] : p[31], o[1] ? p == 64'd0 : p[31:0] == 32'd0, 2'b00};
    e.fw  = sv ? 2'b01 : 2'b00;
    return e;
  endfunction

  // Presents an operation for exactly one accept edge, then scrambles the inputs.
  task automatic issue(input logic [1:0] o, input logic sv, input logic [31:0] av, bv, cv);
    @(negedge clk);
    op = o; s = sv; a = av; b = bv; acc = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); s = 1'($urandom); a = $urandom; b = $urandom; acc = $urandom;
  endtask

  // Counts cycles since accept until done; -1 when the bound expires.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) k = -1;
  endtask

  task automatic test_reset;
    exp_t e;
    int k;
    start = 1'b1; op = 2'b11; a = 32'h1234; b = 32'h55;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0 ||
        cond_flags !== 4'd0 || flag_w !== 2'b00 || long_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b lo=%h hi=%h fl=%b fw=%b lng=%b, required all 0",
               busy, done, result_lo, result_hi, cond_flags, flag_w, long_op);
    end
    reset = 1'b0; op = 2'b00; s = 1'b1; a = 32'd7; b = 32'd6; acc = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, k);
    e = model(2'b00, 1'b1, 32'd7, 32'd6, 32'd0);
    checks++;
    if (k !== 34) begin
      errors++;
      $display("FAIL first_start_latency: got %0d required 34", k);
    end
    checks++;
    if (result_lo !== 32'd42 || result_lo !== e.lo || cond_flags !== 4'b0000 || flag_w !== 2'b01 || long_op !== 1'b0) begin
      errors++;
      $display("FAIL first_start_result: lo=%0d fl=%b fw=%b lng=%b required 42 0000 01 0",
               result_lo, cond_flags, flag_w, long_op);
    end
  endtask

  task automatic test_directed;
    logic [1:0]  to [6] = '{2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b11};
    logic        ts [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ta [6] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'hFFFFFFFD};
    logic [31:0] tb [6] = '{32'd6, 32'd5, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'd0};
    logic [31:0] tlo[6] = '{32'd42, 32'hFFFFFFF1, 32'h1, 32'h0, 32'h0, 32'h0};
    logic [31:0] thi[6] = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h40000000, 32'h0};
    logic [3:0]  tfl[6] = '{4'b0000, 4'b1000, 4'b1000, 4'b0100, 4'b0000, 4'b0100};
    int k;
    for (int i = 0; i < 6; i++) begin
      issue(to[i], ts[i], ta[i], tb[i], 32'd0);
      wait_done(1, k);
      checks++;
      if (k !== 34 || result_lo !== tlo[i] || result_hi !== thi[i] || cond_flags !== tfl[i] ||
          flag_w !== (ts[i] ? 2'b01 : 2'b00) || long_op !== to[i][1]) begin
        errors++;
        $display("FAIL directed_%0d: lat=%0d lo=%h hi=%h fl=%b fw=%b lng=%b required 34 %h %h %b %b %b",
                 i, k, result_lo, result_hi, cond_flags, flag_w, long_op,
                 tlo[i], thi[i], tfl[i], ts[i] ? 2'b01 : 2'b00, to[i][1]);
      end
    end
  endtask

  task automatic test_random;
    exp_t e;
    int k;
    logic [1:0] o;
    logic sv;
    logic [31:0] av, bv, cv;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); sv = 1'($urandom); av = $urandom; bv = $urandom; cv = $urandom;
      if (i % 8 == 0) av = 32'd0;
      if (i % 8 == 1) bv = 32'h80000000;
      issue(o, sv, av, bv, cv);
      e = model(o, sv, av, bv, cv);
      wait_done(1, k);
      checks++;
      if (k !== 34 || result_lo !== e.lo || (e.lng && result_hi !== e.hi) || (!e.lng && result_hi !== 32'd0) ||
          cond_flags !== e.fl || flag_w !== e.fw || long_op !== e.lng) begin
        errors++;
        $display("FAIL random_%0d op=%0d a=%h b=%h acc=%h: lat=%0d lo=%h hi=%h fl=%b fw=%b lng=%b required 34 %h %h %b %b %b",
                 i, o, av, bv, cv, k, result_lo, result_hi, cond_flags, flag_w, long_op,
                 e.lo, e.lng ? e.hi : 32'd0, e.fl, e.fw, e.lng);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result_lo !== e.lo || cond_flags !== e.fl || long_op !== e.lng) begin
        errors++;
        $display("FAIL hold_%0d: done=%b lo=%h fl=%b lng=%b required 0 %h %b %b",
                 i, done, result_lo, cond_flags, long_op, e.lo, e.fl, e.lng);
      end
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int k;
    issue(2'b01, 1'b1, 32'd1000, 32'd3000, 32'd77);
    e = model(2'b01, 1'b1, 32'd1000, 32'd3000, 32'd77);
    repeat (4) @(negedge clk);
    op = 2'b10; s = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; acc = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, k);
    checks++;
    if (k !== 34 || result_lo !== e.lo || result_hi !== 32'd0 || flag_w !== e.fw || long_op !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d lo=%h hi=%h fw=%b lng=%b required 34 %h 0 %b 0",
               k, result_lo, result_hi, flag_w, long_op, e.lo, e.fw);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e1, e2;
    int k1, k2;
    e1 = model(2'b10, 1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 32'd0);
    e2 = model(2'b11, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0);
    issue(2'b10, 1'b1, 32'hCAFEF00D, 32'h0BADBEEF, 32'd0);
    wait_done(1, k1);
    checks++;
    if (k1 !== 34 || result_lo !== e1.lo || result_hi !== e1.hi || cond_flags !== e1.fl) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d lo=%h hi=%h fl=%b required 34 %h %h %b",
               k1, result_lo, result_hi, cond_flags, e1.lo, e1.hi, e1.fl);
    end
    op = 2'b11; s = 1'b1; a = 32'h7FFFFFFF; b = 32'hFFFFFFFF; acc = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
    end
    wait_done(1, k2);
    checks++;
    if (k1 + k2 !== 68 || result_lo !== e2.lo || result_hi !== e2.hi || cond_flags !== e2.fl || long_op !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: total=%0d lo=%h hi=%h fl=%b lng=%b required 68 %h %h %b 1",
               k1 + k2, result_lo, result_hi, cond_flags, long_op, e2.lo, e2.hi, e2.fl);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    issue(2'b00, 1'b1, 32'd9, 32'd9, 32'd0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result_lo !== 32'd0 || result_hi !== 32'd0 ||
        cond_flags !== 4'd0 || flag_w !== 2'b00 || long_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b lo=%h hi=%h fl=%b fw=%b lng=%b required all 0",
               busy, done, result_lo, result_hi, cond_flags, flag_w, long_op);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_abandon: %0d active cycles after reset, required 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
